// File: rtl/sid_dac_pkg.sv
// Shared types and constants for the dual MCP4921 serializer that follows the sid core.
package sid_dac_pkg;

  typedef enum logic [1:0] {
    DAC_IDLE,
    DAC_SHIFT,
    DAC_CSH,
    DAC_LDAC
  } dac_state_e;

  localparam int DAC_FRAME_BITS = 16;

  // A/B=0, BUF=0, GA=1 (1x gain), SHDN=1 (active)
  localparam logic [3:0] DAC_CFG_DEFAULT = 4'b0011;

endpackage

// File: rtl/sid_dac_phase_ctr.sv
// Half-period timer: counts 0..CLK_DIV-1 and toggles the SCK phase at each wrap while enabled.
module sid_dac_phase_ctr #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic sck_en,
  output logic phase_end,
  output logic sck_phase
);

  localparam logic [3:0] LAST = 4'(CLK_DIV - 1);

  logic [3:0] cnt;

  assign phase_end = !clear && (cnt == LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      cnt       <= '0;
      sck_phase <= 1'b0;
    end else if (phase_end) begin
      cnt <= '0;
      if (sck_en) sck_phase <= ~sck_phase;
    end else begin
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/sid_dac_serializer.sv
// Shifts both sid voice-mix samples into two MCP4921 DACs sharing SCK, CS and LDAC,
// with a one-deep pending buffer so a strobe arriving mid-frame is kept.
//
//   state     | meaning
//   DAC_IDLE  | pads idle; load pending pair or live strobe
//   DAC_SHIFT | cs_b low, 16 bits MSB first, shift on last high cycle of each bit
//   DAC_CSH   | cs_b high, CLK_DIV cycles of hold before latching
//   DAC_LDAC  | le_b low for CLK_DIV cycles, outputs update
module sid_dac_serializer
  import sid_dac_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter logic [3:0]  DAC_CFG = DAC_CFG_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [11:0] sample_1_i,
  input  logic [11:0] sample_2_i,
  input  logic        start_i,
  output logic        dac_clk_o,
  output logic        dac_dat_1_o,
  output logic        dac_dat_2_o,
  output logic        dac_cs_b_o,
  output logic        dac_le_b_o,
  output logic        busy_o,
  output logic        dropped_o
);

  localparam logic [3:0] LAST_BIT = 4'(DAC_FRAME_BITS - 1);

  dac_state_e  state;
  logic [3:0]  bit_cnt;
  logic [15:0] shreg_1;
  logic [15:0] shreg_2;
  logic        pend_v;
  logic [11:0] pend_1;
  logic [11:0] pend_2;
  logic        phase_end;
  logic        sck_phase;

  sid_dac_phase_ctr #(
    .CLK_DIV(CLK_DIV)
  ) u_phase (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear    (state == DAC_IDLE),
    .sck_en   (state == DAC_SHIFT),
    .phase_end(phase_end),
    .sck_phase(sck_phase)
  );

  // Shift registers fill with zeros, so dat returns to 0 once the frame is out.
  assign dac_clk_o   = sck_phase;
  assign dac_dat_1_o = shreg_1[15];
  assign dac_dat_2_o = shreg_2[15];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= DAC_IDLE;
      bit_cnt    <= '0;
      shreg_1    <= '0;
      shreg_2    <= '0;
      pend_v     <= 1'b0;
      pend_1     <= '0;
      pend_2     <= '0;
      dac_cs_b_o <= 1'b1;
      dac_le_b_o <= 1'b1;
      busy_o     <= 1'b0;
      dropped_o  <= 1'b0;
    end else begin
      dropped_o <= 1'b0;
      case (state)
        DAC_IDLE: begin
          if (pend_v || start_i) begin
            shreg_1    <= {DAC_CFG, pend_v ? pend_1 : sample_1_i};
            shreg_2    <= {DAC_CFG, pend_v ? pend_2 : sample_2_i};
            bit_cnt    <= '0;
            dac_cs_b_o <= 1'b0;
            busy_o     <= 1'b1;
            state      <= DAC_SHIFT;
          end
          // Consuming the pending pair while a new strobe arrives refills it without a drop.
          if (pend_v && start_i) begin
            pend_1 <= sample_1_i;
            pend_2 <= sample_2_i;
          end else if (pend_v) begin
            pend_v <= 1'b0;
          end
        end
        DAC_SHIFT: begin
          if (phase_end && sck_phase) begin
            shreg_1 <= {shreg_1[14:0], 1'b0};
            shreg_2 <= {shreg_2[14:0], 1'b0};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == LAST_BIT) begin
              dac_cs_b_o <= 1'b1;
              state      <= DAC_CSH;
            end
          end
        end
        DAC_CSH: begin
          if (phase_end) begin
            dac_le_b_o <= 1'b0;
            state      <= DAC_LDAC;
          end
        end
        DAC_LDAC: begin
          if (phase_end) begin
            dac_le_b_o <= 1'b1;
            busy_o     <= 1'b0;
            state      <= DAC_IDLE;
          end
        end
        default: state <= DAC_IDLE;
      endcase

      if (state != DAC_IDLE && start_i) begin
        pend_1    <= sample_1_i;
        pend_2    <= sample_2_i;
        pend_v    <= 1'b1;
        dropped_o <= pend_v;
      end
    end
  end

endmodule

// File: tb/tb_sid_dac_serializer.sv
// Runs CLK_DIV=2 and CLK_DIV=1 serializers side by side against a frame-timing reference model.
module tb_sid_dac_serializer;

  localparam logic [3:0] CFG = 4'b0011;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [11:0] s1;
  logic [11:0] s2;
  logic [1:0]  dclk, dd1, dd2, dcs, dle, dbusy, ddrop;

  always #5 clk_i = ~clk_i;

  sid_dac_serializer #(.CLK_DIV(2)) u_dut_d2 (
    .clk_i(clk_i), .rst_i(rst_i), .sample_1_i(s1), .sample_2_i(s2), .start_i(start_i),
    .dac_clk_o(dclk[0]), .dac_dat_1_o(dd1[0]), .dac_dat_2_o(dd2[0]),
    .dac_cs_b_o(dcs[0]), .dac_le_b_o(dle[0]), .busy_o(dbusy[0]), .dropped_o(ddrop[0])
  );

  sid_dac_serializer #(.CLK_DIV(1)) u_dut_d1 (
    .clk_i(clk_i), .rst_i(rst_i), .sample_1_i(s1), .sample_2_i(s2), .start_i(start_i),
    .dac_clk_o(dclk[1]), .dac_dat_1_o(dd1[1]), .dac_dat_2_o(dd2[1]),
    .dac_cs_b_o(dcs[1]), .dac_le_b_o(dle[1]), .busy_o(dbusy[1]), .dropped_o(ddrop[1])
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int dv [2] = '{2, 1};

  // reference model: frame start edge, active flag, pending pair, words in flight
  int          ft [2];
  bit          fa [2];
  bit          pv [2];
  bit          edrop [2];
  logic [11:0] p1 [2];
  logic [11:0] p2 [2];
  logic [15:0] w1 [2];
  logic [15:0] w2 [2];

  // pad monitor: bits captured on SCK rising edges
  logic [15:0] cap1 [2];
  logic [15:0] cap2 [2];
  logic        prev_ck [2];
  logic        prev_le [2];
  logic        prev_cs [2];

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_edge(input int i);
    int d;
    d = dv[i];
    edrop[i] = 1'b0;
    if (rst_i) begin
      fa[i] = 1'b0;
      pv[i] = 1'b0;
    end else if (!fa[i] || (cyc - ft[i]) >= 34 * d + 1) begin
      fa[i] = 1'b0;
      if (pv[i]) begin
        ft[i] = cyc;
        fa[i] = 1'b1;
        w1[i] = {CFG, p1[i]};
        w2[i] = {CFG, p2[i]};
        if (start_i) begin
          p1[i] = s1;
          p2[i] = s2;
        end else begin
          pv[i] = 1'b0;
        end
      end else if (start_i) begin
        ft[i] = cyc;
        fa[i] = 1'b1;
        w1[i] = {CFG, s1};
        w2[i] = {CFG, s2};
      end
    end else if (start_i) begin
      edrop[i] = pv[i];
      p1[i] = s1;
      p2[i] = s2;
      pv[i] = 1'b1;
    end
  endtask

  task automatic check_outputs(input int i);
    int    d, off, k, ph;
    logic  e_cs, e_le, e_ck, e_d1, e_d2, e_busy;
    string pfx;
    d      = dv[i];
    off    = cyc + 1 - ft[i];
    e_cs   = 1'b1;
    e_le   = 1'b1;
    e_ck   = 1'b0;
    e_d1   = 1'b0;
    e_d2   = 1'b0;
    e_busy = 1'b0;
    if (fa[i] && off >= 1 && off <= 34 * d) begin
      e_busy = 1'b1;
      if (off <= 32 * d) begin
        e_cs = 1'b0;
        k    = (off - 1) / (2 * d);
        ph   = (off - 1) % (2 * d);
        e_ck = (ph >= d);
        e_d1 = w1[i][15 - k];
        e_d2 = w2[i][15 - k];
      end else if (off > 33 * d) begin
        e_le = 1'b0;
      end
    end
    pfx = $sformatf("D%0d", d);
    chk({pfx, " cs_b"},    16'(dcs[i]),   16'(e_cs));
    chk({pfx, " le_b"},    16'(dle[i]),   16'(e_le));
    chk({pfx, " sck"},     16'(dclk[i]),  16'(e_ck));
    chk({pfx, " dat_1"},   16'(dd1[i]),   16'(e_d1));
    chk({pfx, " dat_2"},   16'(dd2[i]),   16'(e_d2));
    chk({pfx, " busy"},    16'(dbusy[i]), 16'(e_busy));
    chk({pfx, " dropped"}, 16'(ddrop[i]), 16'(edrop[i]));

    if (!dcs[i] && prev_cs[i]) begin
      cap1[i] = '0;
      cap2[i] = '0;
    end
    if (dclk[i] && !prev_ck[i]) begin
      cap1[i] = {cap1[i][14:0], dd1[i]};
      cap2[i] = {cap2[i][14:0], dd2[i]};
    end
    if (!dle[i] && prev_le[i]) begin
      chk({pfx, " word_1"}, cap1[i], w1[i]);
      chk({pfx, " word_2"}, cap2[i], w2[i]);
    end
    prev_ck[i] = dclk[i];
    prev_le[i] = dle[i];
    prev_cs[i] = dcs[i];
  endtask

  task automatic step();
    @(posedge clk_i);
    cyc++;
    for (int i = 0; i < 2; i++) model_edge(i);
    @(negedge clk_i);
    for (int i = 0; i < 2; i++) check_outputs(i);
    start_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic strobe(input logic [11:0] a, input logic [11:0] b);
    s1      = a;
    s2      = b;
    start_i = 1'b1;
    step();
  endtask

  initial begin
    rst_i   = 1'b1;
    start_i = 1'b0;
    s1      = '0;
    s2      = '0;
    for (int i = 0; i < 2; i++) begin
      ft[i] = 0; fa[i] = 0; pv[i] = 0; edrop[i] = 0;
      p1[i] = '0; p2[i] = '0; w1[i] = '0; w2[i] = '0;
      cap1[i] = '0; cap2[i] = '0;
      prev_ck[i] = 1'b0; prev_le[i] = 1'b1; prev_cs[i] = 1'b1;
    end
    idle(3);
    rst_i = 1'b0;
    idle(4);

    // single frame
    strobe(12'hABC, 12'h123);
    idle(80);

    // pending strobe mid-frame
    strobe(12'hABC, 12'h123);
    idle(19);
    strobe(12'h555, 12'hAAA);
    idle(160);

    // overrun: third strobe overwrites the pending pair
    strobe(12'h111, 12'h222);
    idle(9);
    strobe(12'h333, 12'h444);
    idle(9);
    strobe(12'h666, 12'h777);
    idle(160);

    // strobe in the IDLE cycle that consumes the pending pair
    strobe(12'h0F0, 12'hF0F);
    idle(9);
    strobe(12'h00F, 12'hFF0);
    idle(58);
    strobe(12'h5A5, 12'hA5A);
    idle(250);

    // reset mid-frame with a pair pending
    strobe(12'hFFF, 12'h000);
    idle(4);
    strobe(12'h123, 12'h456);
    idle(24);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    idle(100);

    // random strobes, samples changing every cycle, rare resets
    repeat (700) begin
      s1 = 12'($urandom);
      s2 = 12'($urandom);
      start_i = ($urandom_range(0, 11) == 0);
      rst_i   = ($urandom_range(0, 399) == 0);
      step();
      rst_i = 1'b0;
    end
    idle(80);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
